// File: rtl/tcs_unit_if.sv
// Operand/result bundle for the tcs_unit add/subtract leaf.
// The master side supplies operands, the slave side (the unit) returns results.
interface tcs_unit_if #(
  parameter int WIDTH = 2
);
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, sub, a, b,
    input  out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, sub, a, b,
    output out_valid, sum, carry, ovf
  );
endinterface

// File: rtl/tcs_unit.sv
// Registered two's-complement add/subtract unit.
// Subtraction is a + ~b + 1: b is inverted and the chain carry-in is set.
// The result goes through a ripple chain of full-adder cells and is
// registered with one cycle of latency; idle cycles hold the last result.
module tcs_unit #(
  parameter int WIDTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  tcs_unit_if.slave    bus
);

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
    return {co, s};
  endfunction

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  logic             valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;

  // Ripple chain: conditional inversion of b, carry-in = sub, cell by cell.
  always_comb begin
    b_eff_s = '0;
    c_s     = '0;
    sum_s   = '0;
    ovf_s   = 1'b0;
    if (bus.sub) begin
      b_eff_s = ~bus.b;
    end else begin
      b_eff_s = bus.b;
    end
    c_s[0] = bus.sub;
    for (int i = 0; i < WIDTH; i++) begin
      {c_s[i+1], sum_s[i]} = full_add(bus.a[i], b_eff_s[i], c_s[i]);
    end
    // Signed overflow: carry into the MSB cell differs from carry out of it.
    ovf_s = c_s[WIDTH] ^ c_s[WIDTH-1];
  end

  // Result register: capture on valid operands, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r   <= sum_s;
        carry_r <= c_s[WIDTH];
        ovf_r   <= ovf_s;
      end else begin
        sum_r   <= sum_r;
        carry_r <= carry_r;
        ovf_r   <= ovf_r;
      end
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_tcs_unit.sv
// Self-checking bench for tcs_unit (WIDTH=2): directed cases with literal
// expectations plus random traffic against an integer-arithmetic model.
module tb_tcs_unit;

  localparam int W   = 2;
  localparam int MOD = 1 << W;

  logic clk;
  logic rst;

  tcs_unit_if #(.WIDTH(W)) bus ();

  tcs_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // model state: what the outputs should show
  int m_valid = 0;
  int m_sum   = 0;
  int m_carry = 0;
  int m_ovf   = 0;

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Reference: integer arithmetic on the operand values.
  task automatic model_op(input int s, input int a, input int b);
    int full;
    int sres;
    if (s != 0) begin
      full = a - b + MOD;                 // a + (2^W-1-b) + 1
      sres = to_signed(a) - to_signed(b);
    end else begin
      full = a + b;
      sres = to_signed(a) + to_signed(b);
    end
    m_sum   = full % MOD;
    m_carry = (full >= MOD) ? 1 : 0;
    m_ovf   = (sres < -(MOD / 2) || sres > MOD / 2 - 1) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".valid"}, int'(bus.out_valid), m_valid);
    check_val({tag, ".sum"},   int'(bus.sum),       m_sum);
    check_val({tag, ".carry"}, int'(bus.carry),     m_carry);
    check_val({tag, ".ovf"},   int'(bus.ovf),       m_ovf);
  endtask

  // Drive one cycle of operands, advance past the edge, check against model.
  task automatic step(input string tag, input int v, input int s, input int a, input int b);
    bus.in_valid = v[0];
    bus.sub      = s[0];
    bus.a        = W'(a);
    bus.b        = W'(b);
    @(posedge clk);
    #1;
    m_valid = v;
    if (v != 0) model_op(s, a, b);
    check_outputs(tag);
  endtask

  typedef struct {
    int s; int a; int b; int sum; int carry; int ovf;
  } vec_t;

  vec_t dir[7] = '{
    '{0, 3, 3, 2, 1, 0},
    '{0, 1, 2, 3, 0, 0},
    '{0, 1, 1, 2, 0, 1},
    '{1, 2, 1, 1, 1, 1},
    '{1, 1, 2, 3, 0, 1},
    '{1, 0, 0, 0, 1, 0},
    '{1, 3, 1, 2, 1, 0}
  };

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.sub      = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    #3;
    check_outputs("reset_async");
    @(posedge clk);
    #1;
    check_outputs("reset_held");
    rst = 1'b0;

    // exhaustive add
    for (int a = 0; a < MOD; a++) begin
      for (int b = 0; b < MOD; b++) begin
        step("add_exh", 1, 0, a, b);
        check_val("add_exh.full", int'({bus.carry, bus.sum}), a + b);
      end
    end

    // exhaustive subtract
    for (int a = 0; a < MOD; a++) begin
      for (int b = 0; b < MOD; b++) begin
        step("sub_exh", 1, 1, a, b);
      end
    end

    // directed literal cases
    foreach (dir[i]) begin
      step("dir", 1, dir[i].s, dir[i].a, dir[i].b);
      check_val("dir.sum_lit",   int'(bus.sum),   dir[i].sum);
      check_val("dir.carry_lit", int'(bus.carry), dir[i].carry);
      check_val("dir.ovf_lit",   int'(bus.ovf),   dir[i].ovf);
    end

    // valid gating 1,0,1
    step("gate1", 1, 0, 1, 1);
    check_val("gate1.sum_lit", int'(bus.sum), 2);
    step("gate0", 0, 0, 3, 3);
    check_val("gate0.valid_lit", int'(bus.out_valid), 0);
    check_val("gate0.sum_lit",   int'(bus.sum), 2);
    step("gate2", 1, 0, 2, 1);
    check_val("gate2.valid_lit", int'(bus.out_valid), 1);
    check_val("gate2.sum_lit",   int'(bus.sum), 3);

    // reset mid-stream between edges, with an operation in flight
    bus.in_valid = 1'b1;
    bus.sub      = 1'b0;
    bus.a        = 2'd3;
    bus.b        = 2'd3;
    #1;
    rst = 1'b1;
    #1;
    m_valid = 0; m_sum = 0; m_carry = 0; m_ovf = 0;
    check_outputs("mid_reset");
    @(posedge clk);
    #1;
    check_outputs("mid_reset_edge");
    rst = 1'b0;
    step("post_reset", 1, 0, 3, 2);
    check_val("post_reset.sum_lit",   int'(bus.sum),   1);
    check_val("post_reset.carry_lit", int'(bus.carry), 1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
